// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator and its cell.
package serial_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    CELL_EQ = 2'b00,
    CELL_GT = 2'b01,
    CELL_LT = 2'b10
  } cell_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } fsm_state_t;

endpackage

// File: rtl/serial_magnitude_comparator_cell.sv
// Combinational comparison cell: folds one operand bit pair into the running A-vs-B state.
module comparator_cell
  import serial_magnitude_comparator_pkg::*;
(
  input  cell_state_t i_state,
  input  logic        i_ai,
  input  logic        i_bi,
  input  logic        i_is_sign_bit,
  input  logic        i_msb_first,
  output cell_state_t o_next_state
);

  logic w_a_wins;

  // A sign bit of 1 means negative, so the usual sense of the pair flips.
  assign w_a_wins = (i_ai & ~i_bi) ^ i_is_sign_bit;

  always_comb begin
    o_next_state = i_state;
    if (i_ai != i_bi) begin
      if (!i_msb_first || (i_state == CELL_EQ)) begin
        o_next_state = w_a_wins ? CELL_GT : CELL_LT;
      end
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: one bit pair per clock, start/busy/done handshake.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_a_gt_b,
  output logic             o_a_eq_b,
  output logic             o_a_lt_b
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  fsm_state_t       r_state;
  fsm_state_t       w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_signed;
  logic [CNT_W-1:0] r_cnt;
  cell_state_t      r_cell;
  cell_state_t      w_cell_next;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_is_sign;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_cnt == LAST_CNT);

  // The scan always reads the same end of the shift registers; direction picks which end.
  assign w_ai      = MSB_FIRST ? r_a_sh[WIDTH-1] : r_a_sh[0];
  assign w_bi      = MSB_FIRST ? r_b_sh[WIDTH-1] : r_b_sh[0];
  assign w_is_sign = r_signed & (MSB_FIRST ? (r_cnt == '0) : (r_cnt == LAST_CNT));

  comparator_cell u_cell (
    .i_state       (r_cell),
    .i_ai          (w_ai),
    .i_bi          (w_bi),
    .i_is_sign_bit (w_is_sign),
    .i_msb_first   (MSB_FIRST),
    .o_next_state  (w_cell_next)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_cell   <= CELL_EQ;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= i_a;
      r_b_sh   <= i_b;
      r_signed <= i_signed_mode;
      r_cnt    <= '0;
      r_cell   <= CELL_EQ;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else if (w_run) begin
      if (MSB_FIRST) begin
        r_a_sh <= {r_a_sh[WIDTH-2:0], 1'b0};
        r_b_sh <= {r_b_sh[WIDTH-2:0], 1'b0};
      end else begin
        r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      end
      r_cell <= w_cell_next;
      if (w_last) begin
        r_cnt <= '0;
        r_gt  <= (w_cell_next == CELL_GT);
        r_eq  <= (w_cell_next == CELL_EQ);
        r_lt  <= (w_cell_next == CELL_LT);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_busy   = w_run;
  assign o_done   = (r_state == ST_DONE);
  assign o_a_gt_b = r_gt;
  assign o_a_eq_b = r_eq;
  assign o_a_lt_b = r_lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench: LSB-first and MSB-first instances driven in lockstep, flags checked against hand values.
`timescale 1ns/1ps
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       signed_mode = 1'b0;

  logic busy_l, done_l, gt_l, eq_l, lt_l;
  logic busy_m, done_m, gt_m, eq_m, lt_m;
  logic [2:0] f_l, f_m;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;
  localparam logic [2:0] F_0  = 3'b000;

  always #5 clk = ~clk;

  assign f_l = {gt_l, eq_l, lt_l};
  assign f_m = {gt_m, eq_m, lt_m};

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_a(a), .i_b(b),
    .i_signed_mode(signed_mode), .o_busy(busy_l), .o_done(done_l),
    .o_a_gt_b(gt_l), .o_a_eq_b(eq_l), .o_a_lt_b(lt_l)
  );

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_a(a), .i_b(b),
    .i_signed_mode(signed_mode), .o_busy(busy_m), .o_done(done_m),
    .o_a_gt_b(gt_m), .o_a_eq_b(eq_m), .o_a_lt_b(lt_m)
  );

  // Called at a falling edge; one-cycle start pulse, returns at the falling edge after the accepting edge.
  task automatic start_cmp(input logic [7:0] va, input logic [7:0] vb, input logic sm);
    a = va; b = vb; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; signed_mode = ~sm;
  endtask

  // Counts falling edges until done (bounded); no checking here.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0;
    while (!done_l && lat < 30) begin
      if (busy_l) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if ({busy_l, done_l, f_l} !== 5'b0) begin n_err++; $display("FAIL reset_lsb: got %b want 00000", {busy_l, done_l, f_l}); end
    n_cmp++; if ({busy_m, done_m, f_m} !== 5'b0) begin n_err++; $display("FAIL reset_msb: got %b want 00000", {busy_m, done_m, f_m}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_equal;
    int lat, bc;
    start_cmp(8'h5A, 8'h5A, 1'b0);
    n_cmp++; if (f_l !== F_0) begin n_err++; $display("FAIL eq_flags_run: got %b want %b", f_l, F_0); end
    wait_done(lat, bc);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL eq_latency: got %0d want 8", lat); end
    n_cmp++; if (bc !== 8) begin n_err++; $display("FAIL eq_busy_cycles: got %0d want 8", bc); end
    n_cmp++; if (done_m !== 1'b1 || busy_m !== 1'b0) begin n_err++; $display("FAIL eq_msb_done: got done=%b busy=%b want 1 0", done_m, busy_m); end
    n_cmp++; if (f_l !== F_EQ) begin n_err++; $display("FAIL eq_lsb_flags: got %b want %b", f_l, F_EQ); end
    n_cmp++; if (f_m !== F_EQ) begin n_err++; $display("FAIL eq_msb_flags: got %b want %b", f_m, F_EQ); end
    repeat (3) @(negedge clk);
    n_cmp++; if (done_l !== 1'b0) begin n_err++; $display("FAIL eq_done_pulse: got %b want 0", done_l); end
    n_cmp++; if (f_l !== F_EQ) begin n_err++; $display("FAIL eq_flags_held: got %b want %b", f_l, F_EQ); end
  endtask

  task automatic test_signedness;
    int lat, bc;
    start_cmp(8'h80, 8'h7F, 1'b0);
    wait_done(lat, bc);
    n_cmp++; if (f_l !== F_GT) begin n_err++; $display("FAIL unsigned_80_7f_lsb: got %b want %b", f_l, F_GT); end
    n_cmp++; if (f_m !== F_GT) begin n_err++; $display("FAIL unsigned_80_7f_msb: got %b want %b", f_m, F_GT); end
    start_cmp(8'h80, 8'h7F, 1'b1);
    wait_done(lat, bc);
    n_cmp++; if (f_l !== F_LT) begin n_err++; $display("FAIL signed_80_7f_lsb: got %b want %b", f_l, F_LT); end
    n_cmp++; if (f_m !== F_LT) begin n_err++; $display("FAIL signed_80_7f_msb: got %b want %b", f_m, F_LT); end
  endtask

  task automatic test_msb_first;
    int lat, bc;
    start_cmp(8'h01, 8'h02, 1'b0);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL msb_latency: got %0d want 8", lat); end
    n_cmp++; if (done_m !== 1'b1) begin n_err++; $display("FAIL msb_done: got %b want 1", done_m); end
    n_cmp++; if (f_m !== F_LT) begin n_err++; $display("FAIL msb_01_02: got %b want %b", f_m, F_LT); end
    n_cmp++; if (f_l !== F_LT) begin n_err++; $display("FAIL lsb_01_02: got %b want %b", f_l, F_LT); end
    start_cmp(8'hFF, 8'h00, 1'b1);
    wait_done(lat, bc);
    n_cmp++; if (f_m !== F_LT) begin n_err++; $display("FAIL msb_signed_ff_00: got %b want %b", f_m, F_LT); end
    n_cmp++; if (f_l !== F_LT) begin n_err++; $display("FAIL lsb_signed_ff_00: got %b want %b", f_l, F_LT); end
  endtask

  task automatic test_start_in_run;
    int lat, bc;
    start_cmp(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    n_cmp++; if (f_l !== F_LT) begin n_err++; $display("FAIL ignore_lsb: got %b want %b", f_l, F_LT); end
    n_cmp++; if (f_m !== F_LT) begin n_err++; $display("FAIL ignore_msb: got %b want %b", f_m, F_LT); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, bc;
    start_cmp(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (busy_l !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b want 1", busy_l); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy_l, done_l, f_l} !== 5'b0) begin n_err++; $display("FAIL abort_lsb_async: got %b want 00000", {busy_l, done_l, f_l}); end
    n_cmp++; if ({busy_m, done_m, f_m} !== 5'b0) begin n_err++; $display("FAIL abort_msb_async: got %b want 00000", {busy_m, done_m, f_m}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (done_l !== 1'b0 || busy_l !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got done=%b busy=%b want 0 0", done_l, busy_l); end
    start_cmp(8'h03, 8'h02, 1'b0);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL abort_restart_latency: got %0d want 8", lat); end
    n_cmp++; if (f_l !== F_GT) begin n_err++; $display("FAIL abort_restart_lsb: got %b want %b", f_l, F_GT); end
    n_cmp++; if (f_m !== F_GT) begin n_err++; $display("FAIL abort_restart_msb: got %b want %b", f_m, F_GT); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    // Entered in the DONE cycle left by the previous test.
    n_cmp++; if (done_l !== 1'b1) begin n_err++; $display("FAIL b2b_in_done: got %b want 1", done_l); end
    start_cmp(8'h00, 8'hFF, 1'b0);
    n_cmp++; if (busy_l !== 1'b1 || done_l !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept: got busy=%b done=%b want 1 0", busy_l, done_l); end
    n_cmp++; if (f_l !== F_0 || f_m !== F_0) begin n_err++; $display("FAIL b2b_flags_clear: got %b %b want 000 000", f_l, f_m); end
    wait_done(lat, bc);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL b2b_latency: got %0d want 8", lat); end
    n_cmp++; if (f_l !== F_LT) begin n_err++; $display("FAIL b2b_lsb: got %b want %b", f_l, F_LT); end
    n_cmp++; if (f_m !== F_LT) begin n_err++; $display("FAIL b2b_msb: got %b want %b", f_m, F_LT); end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_signedness;
    test_msb_first;
    test_start_in_run;
    test_reset_abort;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial magnitude comparator. It is the clocked, parametrised successor of the iterative comparison cell: one operand bit pair is evaluated per clock through a single typical cell, and the cell state is held in a register.
- Adds configurable width, configurable scan direction (LSB-first or MSB-first), and a run-time signed/unsigned mode.
- Adds a start/busy/done handshake.
- Sits in the datapath wherever a small-area A-vs-B decision is needed and multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand width in bits (>= 2).
MSB_FIRST, 0, 0 = scan right-to-left (bit 0 first); 1 = scan left-to-right (bit WIDTH-1 first).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a comparison; sampled only when not busy.
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
signed_mode  input  1  1 = two's-complement compare; sampled with the operands.
busy  output  1  high while bits are being scanned.
done  output  1  one-cycle pulse; results are valid from this cycle on.
a_gt_b  output  1  result: A > B.
a_eq_b  output  1  result: A == B.
a_lt_b  output  1  result: A < B.

Behaviour:
- Reset (async, immediate): FSM goes to IDLE; busy = 0, done = 0, all three result flags = 0; bit counter and cell state cleared. Reset mid-scan aborts the comparison with no result.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, start = 1 at edge k: latch a, b and signed_mode into shift registers. Cell state = EQ, counter = 0, go to RUN.
  - RUN: each edge k+1 .. k+WIDTH consumes one bit pair in scan order and increments the counter. The edge that consumes the last bit (k+WIDTH) moves to DONE.
  - DONE: done = 1 for exactly one cycle. Next edge goes to IDLE unless start = 1, in which case a new comparison is accepted (back-to-back).
  - start in RUN is ignored; operands are not re-sampled.
- busy = 1 exactly in RUN, i.e. for WIDTH cycles. Latency from the accepting edge to done is WIDTH+1 edges (done high in the cycle after edge k+WIDTH).
- Cell state encoding: EQ, GT, LT.
- Cell update, bit pair (ai, bi):
  - LSB-first: ai == bi keeps the state; ai > bi gives GT; ai < bi gives LT. A later (more significant) bit overrides.
  - MSB-first: in EQ, a differing pair sets GT or LT. In GT or LT, the state is locked.
- Signed mode: for the sign bit (bit WIDTH-1) only, the sense is inverted (ai = 1, bi = 0 gives LT; ai = 0, bi = 1 gives GT). It is the last bit processed when LSB-first and the first when MSB-first.
- Result flags:
  - Updated from the final cell state on the edge entering DONE.
  - Exactly one flag is high, and held until the next accepted start or reset.
  - On accepting a new start, all flags clear to 0 and stay 0 during RUN.
- The operands and mode are held internally, so a, b and signed_mode may change freely after the accepting edge.

Decomposition:
- Shared package: cell-state encoding constants (EQ = 2'b00, GT = 2'b01, LT = 2'b10) and FSM state encodings (IDLE, RUN, DONE).
- One sub-module, comparator_cell: combinational next-state function with inputs state, ai, bi, is_sign_bit, msb_first, and output next_state.
  - It is the generalised typical cell and is reusable by the unrolled combinational array.
- Top level holds the FSM, counter, shift registers and result registers.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, unsigned, a=0x5A, b=0x5A, start one cycle -> busy for 8 cycles, done pulse at edge 9, a_eq_b = 1, others 0, held after done.
2. WIDTH=8, MSB_FIRST=0, a=0x80, b=0x7F: unsigned -> a_gt_b = 1; repeat with signed_mode = 1 -> a_lt_b = 1.
3. WIDTH=8, MSB_FIRST=1, a=0x01, b=0x02 -> a_lt_b = 1 with the same 9-edge latency; signed a=0xFF (-1), b=0x00 -> a_lt_b = 1.
4. Start with a=0x10, b=0x20; during RUN pulse start with a=0xF0, b=0x00 -> second request ignored; result a_lt_b = 1 (first operands).
5. Assert reset while the counter is at 4 -> busy, done and all flags go to 0 immediately without waiting for a clock. After release, a new start (a=0x03, b=0x02) -> a_gt_b = 1 with normal latency.
6. Hold start high through the DONE cycle with new operands a=0x00, b=0xFF -> immediate re-accept, busy rises the next cycle, flags clear, then a_lt_b = 1 after 9 edges.
